// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: multi-cycle control for a small 8-bit core.
// Each instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK, drives the
// synchronous program ROM, sequences a 4x8 register file and flag register,
// and issues operands and strobes to an external execution unit.
module fetch_decode_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  pc,
  input  logic [15:0] instr,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  opcode,
  output logic [7:0]  address,
  output logic        readEnable,
  output logic        writeEnable,
  output logic [7:0]  dataCopy,
  input  logic [7:0]  ans,
  input  logic [3:0]  FL,
  input  logic [7:0]  data,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Ops 1..9 are forwarded to the execution unit as ALU operations.
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h9);
  endfunction

  // Control state and architectural state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  logic [7:0]  r_pc;
  logic [7:0]  r_regs [4];
  logic [3:0]  r_flr;

  // Registered outputs and their next values
  logic [7:0]  r_pc_o,     w_pc_o_nxt;
  logic [7:0]  r_a,        w_a_nxt;
  logic [7:0]  r_b,        w_b_nxt;
  logic [3:0]  r_opcode,   w_opcode_nxt;
  logic [7:0]  r_address,  w_addr_nxt;
  logic        r_re,       w_re_nxt;
  logic        r_we,       w_we_nxt;
  logic [7:0]  r_dc,       w_dc_nxt;
  logic        r_halted,   w_halted_nxt;

  // Decoder: in DECODE it looks at the fresh ROM word, otherwise at the held IR
  logic [15:0] w_dec_word;
  logic [3:0]  w_dec_op;
  logic [1:0]  w_dec_rd;
  logic [1:0]  w_dec_rs;
  logic [7:0]  w_dec_imm;
  logic [7:0]  w_pc_seq;
  logic [7:0]  w_pc_next;

  assign w_dec_word = (r_state == S_DECODE) ? instr : r_ir;
  assign w_dec_op   = w_dec_word[15:12];
  assign w_dec_rd   = w_dec_word[11:10];
  assign w_dec_rs   = w_dec_word[9:8];
  assign w_dec_imm  = w_dec_word[7:0];
  assign w_pc_seq   = r_pc + 8'd1;

  // Next-PC selection for the instruction held in IR (used in WRITEBACK)
  always_comb begin
    w_pc_next = w_pc_seq;
    case (w_dec_op)
      OP_JMP: w_pc_next = w_dec_imm;
      OP_JZ: begin
        if (r_flr[0]) begin
          w_pc_next = w_dec_imm;
        end else begin
          w_pc_next = w_pc_seq;
        end
      end
      default: w_pc_next = w_pc_seq;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; start only matters in IDLE and HALT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH:   w_state_nxt = S_DECODE;
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        if (w_dec_op == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  // EXECUTE-cycle outputs are prepared while in DECODE so they are
  // registered exactly for the EXECUTE cycle; operands, address and
  // store data otherwise hold, opcode and strobes return to zero.
  always_comb begin
    w_pc_o_nxt   = r_pc_o;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_addr_nxt   = r_address;
    w_dc_nxt     = r_dc;
    w_opcode_nxt = 4'h0;
    w_re_nxt     = 1'b0;
    w_we_nxt     = 1'b0;
    w_halted_nxt = (w_state_nxt == S_HALT);

    if (w_state_nxt == S_FETCH) begin
      if (r_state == S_WRITEBACK) begin
        w_pc_o_nxt = w_pc_next;
      end else begin
        w_pc_o_nxt = r_pc;
      end
    end else begin
      w_pc_o_nxt = r_pc_o;
    end

    if (r_state == S_DECODE) begin
      if (is_alu(w_dec_op)) begin
        w_opcode_nxt = w_dec_op;
        w_a_nxt      = r_regs[w_dec_rd];
        w_b_nxt      = r_regs[w_dec_rs];
      end else if (w_dec_op == OP_LD) begin
        w_addr_nxt   = w_dec_imm;
        w_re_nxt     = 1'b1;
      end else if (w_dec_op == OP_ST) begin
        w_addr_nxt   = w_dec_imm;
        w_dc_nxt     = r_regs[w_dec_rd];
        w_we_nxt     = 1'b1;
      end else begin
        w_opcode_nxt = 4'h0;
      end
    end else begin
      w_opcode_nxt = 4'h0;
    end
  end

  // Output registers; reset clears them, so an in-flight strobe drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_o    <= 8'h00;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_opcode  <= 4'h0;
      r_address <= 8'h00;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_dc      <= 8'h00;
      r_halted  <= 1'b0;
    end else begin
      r_pc_o    <= w_pc_o_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_opcode  <= w_opcode_nxt;
      r_address <= w_addr_nxt;
      r_re      <= w_re_nxt;
      r_we      <= w_we_nxt;
      r_dc      <= w_dc_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

  // Architectural state: IR latched in DECODE, PC/registers/flags in WRITEBACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir  <= 16'h0000;
      r_pc  <= RESET_PC;
      r_flr <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (r_state == S_DECODE) begin
        r_ir <= instr;
      end
      if (r_state == S_WRITEBACK) begin
        r_pc <= w_pc_next;
        if (is_alu(w_dec_op)) begin
          r_regs[w_dec_rd] <= ans;
          r_flr            <= FL;
        end else if (w_dec_op == OP_LDI) begin
          r_regs[w_dec_rd] <= w_dec_imm;
        end else if (w_dec_op == OP_LD) begin
          r_regs[w_dec_rd] <= data;
        end
      end
    end
  end

  assign pc          = r_pc_o;
  assign A           = r_a;
  assign B           = r_b;
  assign opcode      = r_opcode;
  assign address     = r_address;
  assign readEnable  = r_re;
  assign writeEnable = r_we;
  assign dataCopy    = r_dc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Testbench for fetch_decode_unit: directed programs followed by random
// programs, checked against an instruction-level model of the machine.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  ans = 8'h00;
  logic [3:0]  FL = 4'h0;
  logic [7:0]  data = 8'h00;
  logic [7:0]  pc, A, B, address, dataCopy;
  logic [3:0]  opcode;
  logic        readEnable, writeEnable, halted;

  fetch_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
    .A(A), .B(B), .opcode(opcode), .address(address),
    .readEnable(readEnable), .writeEnable(writeEnable), .dataCopy(dataCopy),
    .ans(ans), .FL(FL), .data(data), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program ROM contents and instruction-level model state
  logic [15:0] rom [256];
  logic [7:0]  m_r [4];
  logic [3:0]  m_flr;
  logic [7:0]  m_pc, m_A, m_B, m_addr, m_dc;
  bit          rnd_res, rnd_start;
  logic [7:0]  d_ans, d_data;
  logic [3:0]  d_fl;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_flr = 4'h0;
    m_A = 8'h00; m_B = 8'h00; m_addr = 8'h00; m_dc = 8'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 256; a++) rom[a] = w;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; start = 1'b0; instr = 16'h0000;
    #1;
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_A", 16'(A), 16'h0);
    chk("rst_B", 16'(B), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_address", 16'(address), 16'h0);
    chk("rst_strobes", 16'({readEnable, writeEnable}), 16'h0);
    chk("rst_dataCopy", 16'(dataCopy), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one instruction; entered and left one time unit after a rising edge
  task automatic do_instr(output bit hit_halt);
    logic [15:0] w;
    logic [7:0]  seen_pc, imm, r_ans, r_data;
    logic [3:0]  op, exp_op, r_fl;
    logic [1:0]  rd, rs;
    bit          alu;
    w = rom[m_pc];
    op = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
    alu = (op >= 4'h1) && (op <= 4'h9);
    // FETCH
    seen_pc = pc;
    chk("fetch_pc", 16'(pc), 16'(m_pc));
    chk("fetch_halted", 16'(halted), 16'h0);
    chk("fetch_ctl", 16'({opcode, readEnable, writeEnable}), 16'h0);
    @(posedge clk); #1;
    // DECODE: synchronous ROM returns the word addressed during FETCH
    instr = rom[seen_pc];
    if (rnd_start) start = 1'($urandom_range(0, 1));
    chk("decode_ctl", 16'({opcode, readEnable, writeEnable}), 16'h0);
    @(posedge clk); #1;
    start = 1'b0;
    // EXECUTE
    exp_op = alu ? op : 4'h0;
    if (alu) begin m_A = m_r[rd]; m_B = m_r[rs]; end
    if (op == 4'hB || op == 4'hC) m_addr = imm;
    if (op == 4'hC) m_dc = m_r[rd];
    chk("ex_opcode", 16'(opcode), 16'(exp_op));
    chk("ex_A", 16'(A), 16'(m_A));
    chk("ex_B", 16'(B), 16'(m_B));
    chk("ex_address", 16'(address), 16'(m_addr));
    chk("ex_dataCopy", 16'(dataCopy), 16'(m_dc));
    chk("ex_readEnable", 16'(readEnable), 16'(op == 4'hB));
    chk("ex_writeEnable", 16'(writeEnable), 16'(op == 4'hC));
    chk("ex_halted", 16'(halted), 16'h0);
    @(posedge clk); #1;
    // WRITEBACK: execution-unit results are valid in this cycle
    r_ans  = rnd_res ? 8'($urandom) : d_ans;
    r_fl   = rnd_res ? 4'($urandom) : d_fl;
    r_data = rnd_res ? 8'($urandom) : d_data;
    ans = r_ans; FL = r_fl; data = r_data;
    chk("wb_ctl", 16'({opcode, readEnable, writeEnable}), 16'h0);
    chk("wb_hold_AB", {A, B}, {m_A, m_B});
    chk("wb_hold_addr_dc", {address, dataCopy}, {m_addr, m_dc});
    chk("wb_halted", 16'(halted), 16'h0);
    @(posedge clk); #1;
    ans = 8'($urandom); FL = 4'($urandom); data = 8'($urandom);
    // Instruction-level effect
    case (op)
      4'hA: begin m_r[rd] = imm; m_pc = m_pc + 8'd1; end
      4'hB: begin m_r[rd] = r_data; m_pc = m_pc + 8'd1; end
      4'hD: m_pc = imm;
      4'hE: m_pc = m_flr[0] ? imm : m_pc + 8'd1;
      default: begin
        if (alu) begin m_r[rd] = r_ans; m_flr = r_fl; end
        m_pc = m_pc + 8'd1;
      end
    endcase
    hit_halt = (op == 4'hF);
    if (hit_halt) chk("halted", 16'(halted), 16'h1);
  endtask

  initial begin
    bit h;
    logic [3:0] rop;
    model_reset();
    rnd_res = 1'b0; rnd_start = 1'b0;
    d_ans = 8'h00; d_fl = 4'h0; d_data = 8'h00;

    // LDI R0,3; ST R0,0; HALT -> halted 12 cycles after start
    fill_rom(16'hF000);
    rom[0] = 16'hA003; rom[1] = 16'hC000; rom[2] = 16'hF000;
    do_reset();
    start_pulse();
    for (int k = 0; k < 3; k++) do_instr(h);
    chk("p1_halt_reached", 16'(h), 16'h1);

    // LDI R1,5; LDI R2,7; ALU1 R1,R2 (ans=12); ST R1,0x10; HALT
    fill_rom(16'hF000);
    rom[0] = 16'hA405; rom[1] = 16'hA807; rom[2] = 16'h1600;
    rom[3] = 16'hC410; rom[4] = 16'hF000;
    do_reset();
    d_ans = 8'd12; d_fl = 4'h0;
    start_pulse();
    for (int k = 0; k < 5; k++) do_instr(h);
    chk("p2_halt_reached", 16'(h), 16'h1);

    // JZ taken with FL=1, then not taken with FL=0
    fill_rom(16'hF000);
    rom[0] = 16'hA001; rom[1] = 16'h2000; rom[2] = 16'hE020;
    rom[8'h20] = 16'h3000; rom[8'h21] = 16'hE040; rom[8'h22] = 16'hF000;
    do_reset();
    d_ans = 8'h44; d_fl = 4'b0001;
    start_pulse();
    do_instr(h); do_instr(h); do_instr(h);
    d_fl = 4'b0000;
    do_instr(h); do_instr(h); do_instr(h);
    chk("p3_halt_reached", 16'(h), 16'h1);

    // JMP 0xFF onto a NOP wraps the PC to 0x00
    fill_rom(16'hF000);
    rom[0] = 16'hD0FF; rom[8'hFF] = 16'h0000;
    do_reset();
    start_pulse();
    do_instr(h); do_instr(h); do_instr(h);

    // Reset during the EXECUTE cycle of a ST
    fill_rom(16'hF000);
    rom[0] = 16'hA009; rom[1] = 16'hC005;
    do_reset();
    start_pulse();
    do_instr(h);
    chk("st_fetch_pc", 16'(pc), 16'h1);
    @(posedge clk); #1; instr = rom[1];
    @(posedge clk); #1;
    chk("st_we_before_reset", 16'(writeEnable), 16'h1);
    #2; rst_n = 1'b0; #1;
    chk("st_we_dropped", 16'(writeEnable), 16'h0);
    chk("st_pc_reset", 16'(pc), 16'h0);
    chk("st_addr_dc_reset", {address, dataCopy}, 16'h0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_pc", 16'(pc), 16'h0);
    chk("idle_ctl", 16'({opcode, readEnable, writeEnable, halted}), 16'h0);
    rom[0] = 16'hC005;
    start_pulse();
    do_instr(h);

    // LD R3,8 with data=A5; ST R3,0x30; HALT; resume via IDLE at PC 3
    fill_rom(16'hF000);
    rom[0] = 16'hBC08; rom[1] = 16'hCC30; rom[2] = 16'hF000; rom[3] = 16'hF000;
    do_reset();
    d_data = 8'hA5;
    start_pulse();
    for (int k = 0; k < 3; k++) do_instr(h);
    start_pulse();
    chk("halt_to_idle", 16'(halted), 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_holds", 16'(halted), 16'h0);
    start_pulse();
    do_instr(h);
    chk("resume_halt", 16'(h), 16'h1);

    // Random programs with random results and stray start pulses
    rnd_res = 1'b1; rnd_start = 1'b1;
    for (int p = 0; p < 10; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'hF && $urandom_range(0, 3) != 0) rop = 4'h0;
        rom[a] = {rop, 12'($urandom)};
      end
      start_pulse();
      for (int k = 0; k < 40; k++) begin
        do_instr(h);
        if (h) break;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
